// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator and checker: default polynomial,
// seed, the Fibonacci feedback helper and the checker state encoding.
package lfsr_pkg;

  localparam int                LFSR_MAX_WIDTH      = 32;
  localparam int                LFSR_WIDTH_DEF      = 11;
  localparam logic [10:0]       LFSR_POLYNOMIAL_DEF = 11'b10100000000;
  localparam logic [10:0]       LFSR_SEED_DEF       = 11'b11011011011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_t;

  // Fibonacci feedback: XOR of every state bit selected by the tap mask.
  // Callers zero-extend narrower states/masks to LFSR_MAX_WIDTH.
  function automatic logic lfsr_fb(input logic [LFSR_MAX_WIDTH-1:0] state,
                                   input logic [LFSR_MAX_WIDTH-1:0] poly);
    return ^(state & poly);
  endfunction

endpackage

// File: rtl/prbs_win_monitor.sv
// Loss-of-lock window monitor: counts enabled bits in fixed windows while the
// checker is locked and flags the bit whose error reaches the loss threshold.
module prbs_win_monitor #(
  parameter int WINDOW         = 64,
  parameter int LOSS_THRESHOLD = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic active,
  input  logic bit_err,
  output logic loss
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int ERR_W = $clog2(LOSS_THRESHOLD + 1);

  logic [WIN_W-1:0] win_cnt_r;
  logic [ERR_W-1:0] win_err_r;
  logic             loss_s;

  // Loss fires on the erroring bit that brings the window count to the threshold.
  always_comb begin
    loss_s = 1'b0;
    if (en && active && bit_err && (win_err_r == ERR_W'(LOSS_THRESHOLD - 1))) begin
      loss_s = 1'b1;
    end else begin
      loss_s = 1'b0;
    end
  end

  assign loss = loss_s;

  // Window position and per-window error tally; both restart after the last
  // bit of a window, on loss, and stay cleared while not locked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_r <= '0;
      win_err_r <= '0;
    end else if (en) begin
      if (!active || loss_s || (win_cnt_r == WIN_W'(WINDOW - 1))) begin
        win_cnt_r <= '0;
        win_err_r <= '0;
      end else begin
        win_cnt_r <= win_cnt_r + WIN_W'(1);
        win_err_r <= win_err_r + ERR_W'(bit_err);
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to the received stream, then runs a
// flywheel reference and counts bit errors until too many land in one window.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH      = LFSR_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = LFSR_POLYNOMIAL_DEF,
  parameter int                    LOCK_COUNT      = 16,
  parameter int                    WINDOW          = 64,
  parameter int                    LOSS_THRESHOLD  = 8,
  parameter int                    ERR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     din,
  input  logic                     clr_err,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int FILL_W  = $clog2(LFSR_WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  prbs_state_t             state_r;
  logic [LFSR_WIDTH-1:0]   h_r;
  logic [FILL_W-1:0]       fill_cnt_r;
  logic [MATCH_W-1:0]      match_cnt_r;
  logic                    locked_r;
  logic                    err_r;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  logic pred_s;
  logic match_s;
  logic filled_s;
  logic bit_err_s;
  logic loss_s;

  // Next-bit prediction from history; an all-zero history never counts as a
  // match so the checker cannot lock onto a dead (stuck-at-0) line.
  always_comb begin
    pred_s    = lfsr_fb(LFSR_MAX_WIDTH'(h_r), LFSR_MAX_WIDTH'(LFSR_POLYNOMIAL));
    filled_s  = (fill_cnt_r == FILL_W'(LFSR_WIDTH));
    match_s   = 1'b0;
    bit_err_s = 1'b0;
    if ((din == pred_s) && (h_r != '0)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
    if ((state_r == LOCKED) && (din != pred_s)) begin
      bit_err_s = 1'b1;
    end else begin
      bit_err_s = 1'b0;
    end
  end

  prbs_win_monitor #(
    .WINDOW         (WINDOW),
    .LOSS_THRESHOLD (LOSS_THRESHOLD)
  ) u_win_monitor (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .active  (state_r == LOCKED),
    .bit_err (bit_err_s),
    .loss    (loss_s)
  );

  // Search/lock state machine with history fill and consecutive-match count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= SEARCH;
      h_r         <= '0;
      fill_cnt_r  <= '0;
      match_cnt_r <= '0;
      locked_r    <= 1'b0;
    end else if (en) begin
      case (state_r)
        SEARCH: begin
          h_r <= {h_r[LFSR_WIDTH-2:0], din};
          if (!filled_s) begin
            fill_cnt_r <= fill_cnt_r + FILL_W'(1);
          end else if (match_s) begin
            if (match_cnt_r == MATCH_W'(LOCK_COUNT - 1)) begin
              state_r     <= LOCKED;
              locked_r    <= 1'b1;
              match_cnt_r <= '0;
            end else begin
              match_cnt_r <= match_cnt_r + MATCH_W'(1);
            end
          end else begin
            match_cnt_r <= '0;
          end
        end
        LOCKED: begin
          // Flywheel: feed the prediction back so bad bits never poison h.
          h_r <= {h_r[LFSR_WIDTH-2:0], pred_s};
          if (loss_s) begin
            state_r     <= SEARCH;
            locked_r    <= 1'b0;
            fill_cnt_r  <= '0;
            match_cnt_r <= '0;
          end
        end
        default: begin
          state_r  <= SEARCH;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle error pulse, low on any cycle without an enabled error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= en & bit_err_s;
    end
  end

  // Saturating error total; clear wins over a same-cycle increment and the
  // count is held across loss of lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= '0;
    end else if (clr_err) begin
      err_cnt_r <= '0;
    end else if (en && bit_err_s && (err_cnt_r != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
    end
  end

  assign locked  = locked_r;
  assign err     = err_r;
  assign err_cnt = err_cnt_r;

endmodule
